// File: rtl/riot_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riot_arb_pkg
// Description : Shared types and constants for the RIOT bus arbiter.
//               - arb_state_t      : arbiter FSM state encoding
//               - HOST_RDATA_FLOAT : value returned when the device does not
//                                    drive its data bus (mcs_oe low)
//               - WAIT_W           : width of the host fairness wait counter
// Revision    : 1.0 - initial release
// ============================================================================
package riot_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_CAPTURE = 1'b1
    } arb_state_t;

    localparam logic [7:0] HOST_RDATA_FLOAT = 8'hFF;
    localparam int         WAIT_W           = 8;

endpackage : riot_arb_pkg
`default_nettype wire

// File: rtl/riot_arb_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module      : riot_arb_wait_cnt
// Description : Saturating count of consecutive cycles in which the host is
//               requesting but not granted. thresh_hit flags that the host
//               has waited MAX_WAIT cycles and is owed a forced bus slot.
// Ports       : phi2       - clock (rising edge)
//               rst        - synchronous active-high reset
//               host_req   - host request level
//               host_gnt   - host grant this cycle
//               thresh_hit - count_q >= MAX_WAIT (registered count)
// Revision    : 1.0 - initial release
// ============================================================================
module riot_arb_wait_cnt
    import riot_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic phi2,
    input  logic rst,
    input  logic host_req,
    input  logic host_gnt,
    output logic thresh_hit
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!host_req || host_gnt) begin
            count_d = '0;
        end else if (count_q != WAIT_SAT) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Compare uses the registered count only, so the grant path that consumes
    // thresh_hit never loops back through host_gnt.
    assign thresh_hit = (count_q >= WAIT_LIMIT);

endmodule : riot_arb_wait_cnt
`default_nettype wire

// File: rtl/riot_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riot_bus_arbiter
// Description : Shares the mcs6530 register/RAM/ROM bus between the 6502 CPU
//               (priority) and a host debug port. The host is granted idle
//               CPU cycles; the read result is captured in the following
//               cycle (device read latency of one cycle).
//               Optional fairness build (macro RIOT_ARB_FAIRNESS_EN): after
//               MAX_WAIT denied cycles the host steals one CPU read cycle,
//               stalling the CPU with cpu_rdy low.
// Ports       : phi2/rst                         - clock, sync reset
//               cpu_req/we_n/a/di/rs0, cpu_rdy   - CPU side
//               host_req/we/a/rs0/wdata          - host request
//               host_gnt/done/rdata/err          - host response
//               mcs_we_n/a/di/rs0, mcs_do/oe     - 6530 device side
// Revision    : 1.0 - initial release
// ============================================================================
module riot_bus_arbiter
    import riot_arb_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 8
) (
    input  logic              phi2,
    input  logic              rst,
    // CPU side
    input  logic              cpu_req,
    input  logic              cpu_we_n,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [7:0]        cpu_di,
    input  logic              cpu_rs0,
    output logic              cpu_rdy,
    // host side
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_a,
    input  logic              host_rs0,
    input  logic [7:0]        host_wdata,
    output logic              host_gnt,
    output logic              host_done,
    output logic [7:0]        host_rdata,
    output logic              host_err,
    // device side
    output logic              mcs_we_n,
    output logic [ADDR_W-1:0] mcs_a,
    output logic [7:0]        mcs_di,
    output logic              mcs_rs0,
    input  logic [7:0]        mcs_do,
    input  logic              mcs_oe
);

    arb_state_t state_q,       state_d;
    logic       host_rd_q,     host_rd_d;     // granted access was a read
    logic       rom_wr_q,      rom_wr_d;      // granted access was a ROM write
    logic [7:0] host_rdata_q,  host_rdata_d;
    logic       forced_slot;
    logic [7:0] capt_data;

`ifdef RIOT_ARB_FAIRNESS_EN
    logic wait_hit;

    riot_arb_wait_cnt #(
        .MAX_WAIT   (MAX_WAIT)
    ) u_wait_cnt (
        .phi2       (phi2),
        .rst        (rst),
        .host_req   (host_req),
        .host_gnt   (host_gnt),
        .thresh_hit (wait_hit)
    );

    // Only CPU reads are stolen: a read can be replayed after the stall,
    // a write cannot.
    assign forced_slot = !rst && (state_q == ARB_IDLE) && host_req &&
                         cpu_req && cpu_we_n && wait_hit;
    assign cpu_rdy     = !forced_slot;
`else
    assign forced_slot = 1'b0;
    assign cpu_rdy     = 1'b1;
`endif

    // Grant, response and bus mux
    always_comb begin
        host_gnt = 1'b0;
        if (!rst && (state_q == ARB_IDLE) && host_req) begin
            host_gnt = !cpu_req || forced_slot;
        end

        host_done = !rst && (state_q == ARB_CAPTURE);
        host_err  = host_done && rom_wr_q;

        // Device data is live during CAPTURE; expose it immediately so
        // host_rdata is valid alongside host_done, then hold it in the flop.
        capt_data  = mcs_oe ? mcs_do : HOST_RDATA_FLOAT;
        host_rdata = (host_done && host_rd_q) ? capt_data : host_rdata_q;

        if (host_gnt) begin
            mcs_a    = host_a;
            mcs_di   = host_wdata;
            mcs_rs0  = host_rs0;
            // ROM writes are rejected here so nothing reaches the device.
            mcs_we_n = !(host_we && !host_rs0);
        end else begin
            mcs_a    = cpu_a;
            mcs_di   = cpu_di;
            mcs_rs0  = cpu_rs0;
            mcs_we_n = rst || !cpu_req || cpu_we_n;
        end
    end

    // Next state
    always_comb begin
        state_d      = host_gnt ? ARB_CAPTURE : ARB_IDLE;
        host_rd_d    = host_rd_q;
        rom_wr_d     = rom_wr_q;
        host_rdata_d = host_rdata;
        if (host_gnt) begin
            host_rd_d = !host_we;
            rom_wr_d  = host_we && host_rs0;
        end
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            host_rd_q    <= 1'b0;
            rom_wr_q     <= 1'b0;
            host_rdata_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            host_rd_q    <= host_rd_d;
            rom_wr_q     <= rom_wr_d;
            host_rdata_q <= host_rdata_d;
        end
    end

endmodule : riot_bus_arbiter
`default_nettype wire

// File: tb/tb_riot_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_riot_bus_arbiter
// Description : Self-checking bench for riot_bus_arbiter. A behavioural
//               6530 memory sits on the device bus; a cycle-level reference
//               model predicts every arbiter output from the sharing rules.
//               Directed scenarios are followed by a randomized run.
//               Fairness checks follow RIOT_ARB_FAIRNESS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riot_bus_arbiter;

    localparam int ADDR_W   = 10;
    localparam int MAX_WAIT = 4;
`ifdef RIOT_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    // Addresses at or above this are unmapped: device leaves OE low.
    localparam logic [ADDR_W-1:0] OE_LIMIT = 10'h3F0;

    logic              phi2, rst;
    logic              cpu_req, cpu_we_n, cpu_rs0, cpu_rdy;
    logic [ADDR_W-1:0] cpu_a, host_a, mcs_a;
    logic [7:0]        cpu_di, host_wdata, host_rdata, mcs_di, mcs_do;
    logic              host_req, host_we, host_rs0, host_gnt, host_done, host_err;
    logic              mcs_we_n, mcs_rs0, mcs_oe;

    riot_bus_arbiter #(
        .ADDR_W     (ADDR_W),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .phi2       (phi2),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we_n   (cpu_we_n),
        .cpu_a      (cpu_a),
        .cpu_di     (cpu_di),
        .cpu_rs0    (cpu_rs0),
        .cpu_rdy    (cpu_rdy),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_a     (host_a),
        .host_rs0   (host_rs0),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_done  (host_done),
        .host_rdata (host_rdata),
        .host_err   (host_err),
        .mcs_we_n   (mcs_we_n),
        .mcs_a      (mcs_a),
        .mcs_di     (mcs_di),
        .mcs_rs0    (mcs_rs0),
        .mcs_do     (mcs_do),
        .mcs_oe     (mcs_oe)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    function automatic logic [7:0] ram_init(input int i);
        return (i == 'h0C5) ? 8'h5A : 8'((i * 7) ^ 'h3C);
    endfunction

    function automatic logic [7:0] rom_init(input int i);
        return 8'(~i ^ (i >> 2));
    endfunction

    // ---------------- behavioural 6530 (registered reads) -----------------
    logic [7:0] dev_ram [1024];
    logic [7:0] dev_rom [1024];
    logic [7:0] dev_do;
    logic       dev_oe;
    logic       dev_init;

    always @(posedge phi2) begin
        if (dev_init) begin
            for (int i = 0; i < 1024; i++) begin
                dev_ram[i] <= ram_init(i);
                dev_rom[i] <= rom_init(i);
            end
        end else begin
            dev_do <= mcs_rs0 ? dev_rom[mcs_a] : dev_ram[mcs_a];
            dev_oe <= (mcs_a < OE_LIMIT);
            if (!mcs_we_n) begin
                if (mcs_rs0) dev_rom[mcs_a] <= mcs_di;
                else         dev_ram[mcs_a] <= mcs_di;
            end
        end
    end
    assign mcs_do = dev_do;
    assign mcs_oe = dev_oe;

    // ---------------- reference model state -------------------------------
    logic [7:0] m_ram [1024];
    logic [7:0] m_rom [1024];
    bit         m_busy;      // a host access was granted last cycle
    bit         m_rd_flag;
    bit         m_err_flag;
    logic [7:0] m_capt;
    logic [7:0] m_rdata;
    int         m_wait;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] expected_read(input logic [ADDR_W-1:0] a, input logic rs0);
        if (a >= OE_LIMIT) return 8'hFF;
        return rs0 ? m_rom[a] : m_ram[a];
    endfunction

    // One bus cycle: inputs already driven; check at negedge, advance model.
    task automatic step();
        logic              forced, e_gnt, e_rdy, e_done, e_err, e_we_n, e_rs0;
        logic [ADDR_W-1:0] e_a;
        logic [7:0]        e_di, e_rdata;
        @(negedge phi2);
        forced = FAIR && !rst && !m_busy && host_req && cpu_req && cpu_we_n &&
                 (m_wait >= MAX_WAIT);
        e_gnt   = !rst && !m_busy && host_req && (!cpu_req || forced);
        e_rdy   = !forced;
        e_done  = !rst && m_busy;
        e_err   = e_done && m_err_flag;
        e_rdata = (e_done && m_rd_flag) ? m_capt : m_rdata;
        if (e_gnt) begin
            e_a = host_a; e_di = host_wdata; e_rs0 = host_rs0;
            e_we_n = !(host_we && !host_rs0);
        end else begin
            e_a = cpu_a; e_di = cpu_di; e_rs0 = cpu_rs0;
            e_we_n = rst || !cpu_req || cpu_we_n;
        end
        check("host_gnt",   32'(host_gnt),   32'(e_gnt));
        check("cpu_rdy",    32'(cpu_rdy),    32'(e_rdy));
        check("host_done",  32'(host_done),  32'(e_done));
        check("host_err",   32'(host_err),   32'(e_err));
        check("host_rdata", 32'(host_rdata), 32'(e_rdata));
        check("mcs_we_n",   32'(mcs_we_n),   32'(e_we_n));
        check("mcs_a",      32'(mcs_a),      32'(e_a));
        check("mcs_di",     32'(mcs_di),     32'(e_di));
        check("mcs_rs0",    32'(mcs_rs0),    32'(e_rs0));
        @(posedge phi2);
        if (rst) begin
            m_busy = 0; m_rd_flag = 0; m_err_flag = 0; m_rdata = 8'h00; m_wait = 0;
        end else begin
            if (e_done && m_rd_flag) m_rdata = m_capt;
            if (e_gnt) begin
                m_rd_flag  = !host_we;
                m_err_flag = host_we && host_rs0;
                m_capt     = expected_read(host_a, host_rs0);
                if (host_we && !host_rs0) m_ram[host_a] = host_wdata;
            end else if (cpu_req && !cpu_we_n) begin
                if (cpu_rs0) m_rom[cpu_a] = cpu_di;
                else         m_ram[cpu_a] = cpu_di;
            end
            m_busy = e_gnt;
            m_wait = (!host_req || e_gnt) ? 0 : ((m_wait < 255) ? m_wait + 1 : 255);
        end
        #1;
        if (e_gnt) host_req = 1'b0;   // host drops its request once served
    endtask

    task automatic host_issue(input logic we, input logic [ADDR_W-1:0] a,
                              input logic rs0, input logic [7:0] d);
        host_req = 1'b1; host_we = we; host_a = a; host_rs0 = rs0; host_wdata = d;
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 10'h0C0 + ADDR_W'($urandom_range(0, 7));
            2:       return 10'h3F8 + ADDR_W'($urandom_range(0, 7));
            default: return ADDR_W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; dev_init = 1'b1;
        cpu_req = 0; cpu_we_n = 1; cpu_a = '0; cpu_di = '0; cpu_rs0 = 0;
        host_req = 0; host_we = 0; host_a = '0; host_rs0 = 0; host_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            m_ram[i] = ram_init(i);
            m_rom[i] = rom_init(i);
        end
        m_busy = 0; m_rd_flag = 0; m_err_flag = 0; m_rdata = 8'h00; m_wait = 0;
        m_capt = 8'h00;
        repeat (2) @(posedge phi2);
        #1 dev_init = 1'b0;
        step();                         // reset state, still in reset
        rst = 1'b0;

        // Host read with CPU idle
        host_issue(1'b0, 10'h0C5, 1'b0, 8'h00);
        step(); step();
        check("rd_0C5", 32'(host_rdata), 32'h5A);

        // Contention: CPU read for 3 cycles, then idle
        cpu_req = 1; cpu_we_n = 1; cpu_a = 10'h123;
        host_issue(1'b0, 10'h0C6, 1'b0, 8'h00);
        repeat (3) step();
        cpu_req = 0;
        step(); step();

        // ROM write rejection, then read the ROM location back
        host_issue(1'b1, 10'h010, 1'b1, 8'h77);
        step(); step();
        host_issue(1'b0, 10'h010, 1'b1, 8'h00);
        step(); step();
        check("rom_010", 32'(host_rdata), 32'(rom_init('h010)));

        // Starvation / forced slot under a CPU read stream, then a write stream
        cpu_req = 1; cpu_we_n = 1; cpu_a = 10'h0C3;
        host_issue(1'b0, 10'h0C7, 1'b0, 8'h00);
        repeat (7) step();
        host_issue(1'b0, 10'h0C2, 1'b0, 8'h00);
        cpu_we_n = 0; cpu_a = 10'h0C4; cpu_di = 8'h3E;
        repeat (8) step();
        cpu_req = 0; cpu_we_n = 1;
        step(); step();

        // Reset during CAPTURE
        host_issue(1'b0, 10'h0C4, 1'b0, 8'h00);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_rdata", 32'(host_rdata), 32'h00);
        check("rst_rdy",   32'(cpu_rdy),    32'h1);
        host_issue(1'b0, 10'h0C4, 1'b0, 8'h00);
        step(); step();

        // Back-to-back host requests: write 0C0/0C1, read both back
        host_issue(1'b1, 10'h0C0, 1'b0, 8'hA1); step();
        host_issue(1'b1, 10'h0C1, 1'b0, 8'hB2); step(); step();
        host_issue(1'b0, 10'h0C0, 1'b0, 8'h00); step(); step();
        check("rd_0C0", 32'(host_rdata), 32'hA1);
        host_issue(1'b0, 10'h0C1, 1'b0, 8'h00); step(); step();
        check("rd_0C1", 32'(host_rdata), 32'hB2);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 59) == 0);
            cpu_req  = ($urandom_range(0, 9) < 6);
            cpu_we_n = ($urandom_range(0, 2) != 0);
            cpu_a    = pick_addr();
            cpu_di   = 8'($urandom);
            cpu_rs0  = ($urandom_range(0, 3) == 0);
            if (!host_req) begin
                if ($urandom_range(0, 2) == 0)
                    host_issue(1'($urandom), pick_addr(),
                               ($urandom_range(0, 3) == 0), 8'($urandom));
            end else if ($urandom_range(0, 11) == 0) begin
                host_req = 1'b0;        // withdrawn before grant
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_riot_bus_arbiter
`default_nettype wire
